riscv_csr_exec: RTL and testbench

//  Multi-lane CSR execute unit for the in-order RISC-V core: decodes CSRRW/S/C(I) on NUM_LANES issue

---
 rtl/riscv_csr_exec.sv | 237 +++++++++++++++++++++++
 tb/tb_riscv_csr_exec.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_csr_exec.sv
// riscv_csr_exec
// ---------------------------------------------------------------------------
// CSR execute unit for the in-order core. Each cycle it looks at NUM_LANES
// issue lanes (lane 0 oldest), accepts the oldest CSR instruction, reads the
// CSR file (with a bypass from the writeback port), computes the new value and
// presents a registered result one cycle later. Writeback returns the actual
// CSR write through the wb_* port. Also hosts mcycle/minstret 64-bit counters.
//
// Ports
//   clk, srst_n          clock, synchronous active-low reset
//   cpu_id               mhartid value
//   inst_valid/inst      per-lane valid and instruction word (lane i at [32i+:32])
//   ra_idx/ra_data       per-lane rs1 index (also the uimm) and rs1 value
//   retire_cnt           instructions retired this cycle (minstret increment)
//   wb_write/waddr/wdata CSR write returned from writeback
//   csr_stall            combinational: a younger lane holds a CSR op not taken now
//   res_*                registered result: valid, lane, old value, write request,
//                        write address/data, illegal-access flag
// ---------------------------------------------------------------------------
module riscv_csr_exec #(
    parameter int          NUM_LANES      = 2,
    parameter bit          SUPPORT_MULDIV = 1'b1,
    parameter bit          COUNTER_EN     = 1'b1,
    parameter logic [31:0] MTVEC_RST      = 32'h0000_0000,
    localparam int         LANE_W         = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
    localparam int         CNT_W          = $clog2(NUM_LANES + 1)
) (
    input  logic                    clk,
    input  logic                    srst_n,
    input  logic [31:0]             cpu_id,
    input  logic [NUM_LANES-1:0]    inst_valid,
    input  logic [32*NUM_LANES-1:0] inst,
    input  logic [5*NUM_LANES-1:0]  ra_idx,
    input  logic [32*NUM_LANES-1:0] ra_data,
    input  logic [CNT_W-1:0]        retire_cnt,
    input  logic                    wb_write,
    input  logic [11:0]             wb_waddr,
    input  logic [31:0]             wb_wdata,
    output logic                    csr_stall,
    output logic                    res_valid,
    output logic [LANE_W-1:0]       res_lane,
    output logic [31:0]             res_rdata,
    output logic                    res_write,
    output logic [11:0]             res_waddr,
    output logic [31:0]             res_wdata,
    output logic                    res_illegal
);

    // MXL=1 (RV32), 'I' always, 'M' when the multiplier/divider is present.
    localparam logic [31:0] MISA_VAL     = 32'h4000_0100 | (SUPPORT_MULDIV ? 32'h0000_1000 : 32'h0);
    localparam logic [31:0] MSTATUS_MASK = 32'h0000_0088;   // MIE (3) and MPIE (7)
    localparam logic [31:0] ALIGN4_MASK  = 32'hFFFF_FFFC;

    // ------------------------------------------------------------------
    // Per-lane decode: SYSTEM opcode with funct3 in {1,2,3,5,6,7}.
    // funct3[1:0]==0 covers both 000 (ECALL/EBREAK/...) and 100 (reserved).
    // ------------------------------------------------------------------
    logic [NUM_LANES-1:0] lane_csr;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane_dec
            logic unused_fields;
            assign lane_csr[gi] = inst_valid[gi]
                               && (inst[32*gi +: 7] == 7'b1110011)
                               && (inst[32*gi+12 +: 2] != 2'b00);
            // rd and rs1 fields are not needed here: rd goes with the result
            // lane, and rs1/uimm arrives pre-decoded on ra_idx.
            assign unused_fields = ^{inst[32*gi+7 +: 5], inst[32*gi+15 +: 5]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Arbitration: oldest CSR lane wins; any further CSR lane stalls issue.
    // ------------------------------------------------------------------
    logic              sel_found;
    logic [LANE_W-1:0] sel_lane;
    logic [11:0]       sel_addr;
    logic [2:0]        sel_f3;
    logic [4:0]        sel_idx;
    logic [31:0]       sel_data;
    logic              stall;

    always_comb begin
        sel_found = 1'b0;
        sel_lane  = '0;
        sel_addr  = '0;
        sel_f3    = '0;
        sel_idx   = '0;
        sel_data  = '0;
        stall     = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_csr[i]) begin
                if (!sel_found) begin
                    sel_found = 1'b1;
                    sel_lane  = LANE_W'(i);
                    sel_addr  = inst[32*i+20 +: 12];
                    sel_f3    = inst[32*i+12 +: 3];
                    sel_idx   = ra_idx[5*i +: 5];
                    sel_data  = ra_data[32*i +: 32];
                end else begin
                    stall = 1'b1;
                end
            end
        end
    end

    assign csr_stall = stall;

    // ------------------------------------------------------------------
    // CSR state
    // ------------------------------------------------------------------
    logic [31:0] mstatus_reg, mtvec_reg, mscratch_reg, mepc_reg, mcause_reg;
    logic [63:0] mcycle_reg, mcycle_next;
    logic [63:0] minstret_reg, minstret_next;

    // ------------------------------------------------------------------
    // Read, bypass and new-value computation
    // ------------------------------------------------------------------
    logic        rd_impl;
    logic [31:0] rd_val, old_val, new_val, src_val;
    logic        do_write, illegal;

    always_comb begin
        rd_impl = 1'b1;
        rd_val  = '0;
        case (sel_addr)
            12'h300:          rd_val = mstatus_reg;
            12'h301:          rd_val = MISA_VAL;
            12'h305:          rd_val = mtvec_reg;
            12'h340:          rd_val = mscratch_reg;
            12'h341:          rd_val = mepc_reg;
            12'h342:          rd_val = mcause_reg;
            12'hB00, 12'hC00: rd_val = mcycle_reg[31:0];
            12'hB80, 12'hC80: rd_val = mcycle_reg[63:32];
            12'hB02, 12'hC02: rd_val = minstret_reg[31:0];
            12'hB82, 12'hC82: rd_val = minstret_reg[63:32];
            12'hF14:          rd_val = cpu_id;
            default:          rd_impl = 1'b0;
        endcase
    end

    // A write landing in the same cycle is newer than the stored value.
    assign old_val  = (wb_write && (wb_waddr == sel_addr)) ? wb_wdata : rd_val;
    assign src_val  = sel_f3[2] ? {27'd0, sel_idx} : sel_data;
    // Set/clear with x0 / uimm=0 is a pure read and must not trip the RO check.
    assign do_write = (sel_f3[1:0] == 2'b01) || (sel_idx != 5'd0);
    assign illegal  = !rd_impl || (do_write && (sel_addr[11:10] == 2'b11));

    always_comb begin
        case (sel_f3[1:0])
            2'b01:   new_val = src_val;
            2'b10:   new_val = old_val | src_val;
            2'b11:   new_val = old_val & ~src_val;
            default: new_val = old_val;
        endcase
    end

    // ------------------------------------------------------------------
    // Counters: a writeback to either half replaces that half and
    // suppresses the increment for that cycle.
    // ------------------------------------------------------------------
    always_comb begin
        mcycle_next   = mcycle_reg + 64'd1;
        minstret_next = minstret_reg + 64'(retire_cnt);
        if (wb_write) begin
            case (wb_waddr)
                12'hB00: mcycle_next   = {mcycle_reg[63:32], wb_wdata};
                12'hB80: mcycle_next   = {wb_wdata, mcycle_reg[31:0]};
                12'hB02: minstret_next = {minstret_reg[63:32], wb_wdata};
                12'hB82: minstret_next = {wb_wdata, minstret_reg[31:0]};
                default: ;
            endcase
        end
        if (!COUNTER_EN) begin
            mcycle_next   = '0;
            minstret_next = '0;
        end
    end

    // ------------------------------------------------------------------
    // State and result registers
    // ------------------------------------------------------------------
    logic              res_valid_reg, res_write_reg, res_illegal_reg;
    logic [LANE_W-1:0] res_lane_reg;
    logic [31:0]       res_rdata_reg, res_wdata_reg;
    logic [11:0]       res_waddr_reg;

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            mstatus_reg     <= '0;
            mtvec_reg       <= MTVEC_RST & ALIGN4_MASK;
            mscratch_reg    <= '0;
            mepc_reg        <= '0;
            mcause_reg      <= '0;
            mcycle_reg      <= '0;
            minstret_reg    <= '0;
            res_valid_reg   <= 1'b0;
            res_lane_reg    <= '0;
            res_rdata_reg   <= '0;
            res_write_reg   <= 1'b0;
            res_waddr_reg   <= '0;
            res_wdata_reg   <= '0;
            res_illegal_reg <= 1'b0;
        end else begin
            mcycle_reg   <= mcycle_next;
            minstret_reg <= minstret_next;
            // Writes to read-only or unimplemented addresses fall through.
            if (wb_write) begin
                case (wb_waddr)
                    12'h300: mstatus_reg  <= wb_wdata & MSTATUS_MASK;
                    12'h305: mtvec_reg    <= wb_wdata & ALIGN4_MASK;
                    12'h340: mscratch_reg <= wb_wdata;
                    12'h341: mepc_reg     <= wb_wdata & ALIGN4_MASK;
                    12'h342: mcause_reg   <= wb_wdata;
                    default: ;
                endcase
            end
            res_valid_reg   <= sel_found;
            res_lane_reg    <= sel_lane;
            res_illegal_reg <= sel_found & illegal;
            res_write_reg   <= sel_found & ~illegal & do_write;
            res_waddr_reg   <= sel_addr;
            res_rdata_reg   <= (sel_found && !illegal) ? old_val : 32'd0;
            res_wdata_reg   <= (sel_found && !illegal) ? new_val : 32'd0;
        end
    end

    assign res_valid   = res_valid_reg;
    assign res_lane    = res_lane_reg;
    assign res_rdata   = res_rdata_reg;
    assign res_write   = res_write_reg;
    assign res_waddr   = res_waddr_reg;
    assign res_wdata   = res_wdata_reg;
    assign res_illegal = res_illegal_reg;

endmodule

// File: tb/tb_riscv_csr_exec.sv
// tb_riscv_csr_exec
// ---------------------------------------------------------------------------
// Directed scenarios followed by randomized traffic against a behavioural
// CSR model (associative CSR store with write masks, 64-bit counters).
// ---------------------------------------------------------------------------
module tb_riscv_csr_exec;

    localparam int          NL        = 2;
    localparam logic [31:0] MTVEC_RST = 32'h0000_1000;
    localparam logic [31:0] CPU_ID    = 32'h0000_0007;
    localparam logic [31:0] MISA      = 32'h4000_1100;   // RV32 + I + M
    localparam int F_RW = 1, F_RS = 2, F_RC = 3, F_RWI = 5, F_RSI = 6, F_RCI = 7;

    logic              clk = 1'b0;
    logic              srst_n;
    logic [NL-1:0]     inst_valid;
    logic [32*NL-1:0]  inst;
    logic [5*NL-1:0]   ra_idx;
    logic [32*NL-1:0]  ra_data;
    logic [1:0]        retire_cnt;
    logic              wb_write;
    logic [11:0]       wb_waddr;
    logic [31:0]       wb_wdata;
    logic              csr_stall, res_valid, res_write, res_illegal;
    logic [0:0]        res_lane;
    logic [31:0]       res_rdata, res_wdata;
    logic [11:0]       res_waddr;

    always #5 clk = ~clk;

    riscv_csr_exec #(
        .NUM_LANES(NL), .SUPPORT_MULDIV(1'b1), .COUNTER_EN(1'b1), .MTVEC_RST(MTVEC_RST)
    ) dut (
        .clk(clk), .srst_n(srst_n), .cpu_id(CPU_ID),
        .inst_valid(inst_valid), .inst(inst), .ra_idx(ra_idx), .ra_data(ra_data),
        .retire_cnt(retire_cnt), .wb_write(wb_write), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .csr_stall(csr_stall), .res_valid(res_valid), .res_lane(res_lane), .res_rdata(res_rdata),
        .res_write(res_write), .res_waddr(res_waddr), .res_wdata(res_wdata), .res_illegal(res_illegal)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- behavioural model ----------------
    logic [31:0] csr_mem [logic [11:0]];   // plain read/write CSRs
    logic [31:0] wmask   [logic [11:0]];   // writable bits of each
    logic [63:0] m_cycle, m_instret;

    bit          exp_valid, exp_stall, exp_illegal, exp_write;
    int          exp_lane;
    logic [31:0] exp_rdata, exp_wdata;
    logic [11:0] exp_waddr;

    function automatic bit model_read(input logic [11:0] a, output logic [31:0] v);
        v = '0;
        if (csr_mem.exists(a)) begin
            v = csr_mem[a];
            return 1'b1;
        end
        case (a)
            12'h301:          v = MISA;
            12'hF14:          v = CPU_ID;
            12'hB00, 12'hC00: v = m_cycle[31:0];
            12'hB80, 12'hC80: v = m_cycle[63:32];
            12'hB02, 12'hC02: v = m_instret[31:0];
            12'hB82, 12'hC82: v = m_instret[63:32];
            default:          return 1'b0;
        endcase
        return 1'b1;
    endfunction

    task automatic model_reset();
        wmask[12'h300] = 32'h0000_0088; wmask[12'h305] = 32'hFFFF_FFFC;
        wmask[12'h340] = 32'hFFFF_FFFF; wmask[12'h341] = 32'hFFFF_FFFC;
        wmask[12'h342] = 32'hFFFF_FFFF;
        csr_mem[12'h300] = 0; csr_mem[12'h305] = MTVEC_RST & 32'hFFFF_FFFC;
        csr_mem[12'h340] = 0; csr_mem[12'h341] = 0; csr_mem[12'h342] = 0;
        m_cycle = 0; m_instret = 0;
    endtask

    // Expected result for the inputs currently applied, from pre-edge state.
    task automatic predict();
        int          n;
        logic [31:0] ins, src, rv;
        logic [11:0] a;
        logic [4:0]  idx;
        bit          impl, wr;
        n = 0; exp_lane = 0; exp_valid = 0; exp_illegal = 0; exp_write = 0;
        exp_rdata = 0; exp_wdata = 0; exp_waddr = 0;
        for (int i = 0; i < NL; i++) begin
            ins = inst[32*i +: 32];
            if (inst_valid[i] && ins[6:0] == 7'h73 && ins[14:12] != 3'd0 && ins[14:12] != 3'd4) begin
                if (n == 0) exp_lane = i;
                n++;
            end
        end
        exp_stall = (n > 1);
        if (n == 0 || !srst_n) return;
        ins = inst[32*exp_lane +: 32];
        idx = ra_idx[5*exp_lane +: 5];
        a   = ins[31:20];
        src = (ins[14:12] >= 3'd5) ? {27'd0, idx} : ra_data[32*exp_lane +: 32];
        wr  = (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) || (idx != 0);
        impl = model_read(a, rv);
        if (wb_write && wb_waddr == a) rv = wb_wdata;
        exp_valid = 1;
        if (!impl || (wr && a >= 12'hC00)) begin
            exp_illegal = 1;
            return;
        end
        case (ins[14:12])
            3'd1, 3'd5: exp_wdata = src;
            3'd2, 3'd6: exp_wdata = rv | src;
            default:    exp_wdata = rv & ~src;
        endcase
        exp_write = wr; exp_rdata = rv; exp_waddr = a;
    endtask

    task automatic model_clock();
        logic [63:0] nc, ni;
        if (!srst_n) begin
            model_reset();
            return;
        end
        nc = m_cycle + 1;
        ni = m_instret + retire_cnt;
        if (wb_write) begin
            if (wmask.exists(wb_waddr)) csr_mem[wb_waddr] = wb_wdata & wmask[wb_waddr];
            if (wb_waddr == 12'hB00) nc = {m_cycle[63:32], wb_wdata};
            if (wb_waddr == 12'hB80) nc = {wb_wdata, m_cycle[31:0]};
            if (wb_waddr == 12'hB02) ni = {m_instret[63:32], wb_wdata};
            if (wb_waddr == 12'hB82) ni = {wb_wdata, m_instret[31:0]};
        end
        m_cycle = nc;
        m_instret = ni;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clear_inputs();
        inst_valid = '0; inst = '0; ra_idx = '0; ra_data = '0; retire_cnt = '0;
        wb_write = 1'b0; wb_waddr = '0; wb_wdata = '0;
    endtask

    task automatic set_lane(input int ln, input int f3, input logic [11:0] a,
                            input logic [4:0] idx, input logic [31:0] d);
        inst_valid[ln]      = 1'b1;
        inst[32*ln +: 32]   = {a, idx, 3'(f3), 5'd1, 7'h73};
        ra_idx[5*ln +: 5]   = idx;
        ra_data[32*ln +: 32] = d;
    endtask

    task automatic set_wb(input logic [11:0] a, input logic [31:0] d);
        wb_write = 1'b1; wb_waddr = a; wb_wdata = d;
    endtask

    // Inputs stay applied until after the post-edge sample.
    task automatic tick();
        predict();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        srst_n = 1'b0;
        clear_inputs();
        set_lane(0, F_RW, 12'h340, 5'd3, 32'h1234_5678);
        set_wb(12'h340, 32'h5555_5555);
        repeat (3) tick();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", res_valid); end
        checks++; if (res_write !== 1'b0 || res_illegal !== 1'b0) begin errors++; $display("FAIL reset_flags: write=%b illegal=%b want 0/0", res_write, res_illegal); end
        checks++; if (res_rdata !== 32'd0 || res_wdata !== 32'd0) begin errors++; $display("FAIL reset_data: rdata=%h wdata=%h want 0/0", res_rdata, res_wdata); end
        srst_n = 1'b1;
        clear_inputs();
        set_lane(0, F_RS, 12'h305, 5'd0, 32'hFFFF_FFFF);
        tick();
        checks++; if (res_rdata !== MTVEC_RST) begin errors++; $display("FAIL reset_mtvec: got %h want %h", res_rdata, MTVEC_RST); end
        clear_inputs();
        set_lane(0, F_RS, 12'h340, 5'd0, 32'h0);
        tick();
        checks++; if (res_rdata !== 32'd0) begin errors++; $display("FAIL reset_mscratch: got %h want 0", res_rdata); end
    endtask

    task automatic test_scratch();
        clear_inputs();
        set_lane(0, F_RW, 12'h340, 5'd9, 32'hDEAD_BEEF);
        tick();
        checks++; if (res_valid !== 1'b1 || res_lane !== 1'b0) begin errors++; $display("FAIL rw_valid_lane: valid=%b lane=%0d want 1/0", res_valid, res_lane); end
        checks++; if (res_write !== 1'b1 || res_waddr !== 12'h340 || res_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rw_write: write=%b addr=%h data=%h want 1/340/deadbeef", res_write, res_waddr, res_wdata); end
        clear_inputs();
        set_wb(12'h340, 32'hDEAD_BEEF);
        tick();
        clear_inputs();
        set_lane(0, F_RS, 12'h340, 5'd0, 32'hFFFF_FFFF);
        tick();
        checks++; if (res_rdata !== 32'hDEAD_BEEF || res_write !== 1'b0) begin errors++; $display("FAIL rs_x0_read: rdata=%h write=%b want deadbeef/0", res_rdata, res_write); end
    endtask

    task automatic test_stall();
        clear_inputs();
        set_lane(0, F_RS, 12'h340, 5'd0, 32'h0);
        set_lane(1, F_RS, 12'h342, 5'd0, 32'h0);
        #1;
        checks++; if (csr_stall !== 1'b1) begin errors++; $display("FAIL stall_two: got %b want 1", csr_stall); end
        tick();
        checks++; if (res_lane !== 1'b0 || res_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stall_lane0: lane=%0d rdata=%h want 0/deadbeef", res_lane, res_rdata); end
        inst_valid[0] = 1'b0;
        #1;
        checks++; if (csr_stall !== 1'b0) begin errors++; $display("FAIL stall_one: got %b want 0", csr_stall); end
        tick();
        checks++; if (res_valid !== 1'b1 || res_lane !== 1'b1) begin errors++; $display("FAIL lane1: valid=%b lane=%0d want 1/1", res_valid, res_lane); end
        clear_inputs();
        inst[31:0] = 32'h0000_0073;   // ECALL: not a CSR op
        inst_valid[0] = 1'b1;
        tick();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL non_csr: valid=%b want 0", res_valid); end
    endtask

    task automatic test_illegal();
        logic [31:0] cyc;
        clear_inputs();
        set_lane(0, F_RW, 12'hC00, 5'd4, 32'h1);
        tick();
        checks++; if (res_valid !== 1'b1 || res_illegal !== 1'b1 || res_write !== 1'b0 || res_rdata !== 32'd0) begin errors++; $display("FAIL rw_cycle: v=%b ill=%b wr=%b rd=%h want 1/1/0/0", res_valid, res_illegal, res_write, res_rdata); end
        clear_inputs();
        set_lane(0, F_RS, 12'hC00, 5'd0, 32'hFFFF);
        cyc = m_cycle[31:0];
        tick();
        checks++; if (res_illegal !== 1'b0 || res_rdata !== cyc) begin errors++; $display("FAIL rs_cycle: ill=%b rdata=%h want 0/%h", res_illegal, res_rdata, cyc); end
        clear_inputs();
        set_lane(0, F_RWI, 12'h7C0, 5'd1, 32'h0);
        tick();
        checks++; if (res_illegal !== 1'b1 || res_write !== 1'b0) begin errors++; $display("FAIL unimpl: ill=%b wr=%b want 1/0", res_illegal, res_write); end
        clear_inputs();
        set_lane(0, F_RS, 12'hF14, 5'd0, 32'h0);
        tick();
        checks++; if (res_illegal !== 1'b0 || res_rdata !== CPU_ID) begin errors++; $display("FAIL mhartid: ill=%b rdata=%h want 0/%h", res_illegal, res_rdata, CPU_ID); end
        clear_inputs();
        set_lane(1, F_RW, 12'h301, 5'd2, 32'h0);
        tick();
        checks++; if (res_illegal !== 1'b0 || res_write !== 1'b1 || res_rdata !== MISA) begin errors++; $display("FAIL misa_write: ill=%b wr=%b rdata=%h want 0/1/%h", res_illegal, res_write, res_rdata, MISA); end
    endtask

    task automatic test_bypass();
        clear_inputs();
        set_lane(0, F_RS, 12'h342, 5'd0, 32'h0);
        set_wb(12'h342, 32'd5);
        tick();
        checks++; if (res_rdata !== 32'd5) begin errors++; $display("FAIL bypass_mcause: got %h want 5", res_rdata); end
        clear_inputs();
        set_wb(12'h341, 32'h0000_1003);
        tick();
        clear_inputs();
        set_lane(0, F_RSI, 12'h341, 5'd0, 32'h0);
        tick();
        checks++; if (res_rdata !== 32'h0000_1000) begin errors++; $display("FAIL mepc_align: got %h want 00001000", res_rdata); end
    endtask

    task automatic test_mstatus();
        clear_inputs();
        set_lane(0, F_RW, 12'h300, 5'd7, 32'hFFFF_FFFF);
        tick();
        checks++; if (res_rdata !== 32'd0 || res_wdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mstatus_rw: rdata=%h wdata=%h want 0/ffffffff", res_rdata, res_wdata); end
        clear_inputs();
        set_wb(12'h300, 32'hFFFF_FFFF);
        tick();
        clear_inputs();
        set_lane(0, F_RCI, 12'h300, 5'd8, 32'h0);
        tick();
        checks++; if (res_rdata !== 32'h88 || res_wdata !== 32'h80 || res_write !== 1'b1) begin errors++; $display("FAIL mstatus_rci: rdata=%h wdata=%h wr=%b want 88/80/1", res_rdata, res_wdata, res_write); end
    endtask

    task automatic test_counters();
        clear_inputs(); set_wb(12'hB80, 32'h0000_1234); tick();
        clear_inputs(); set_wb(12'hB00, 32'hFFFF_FFFF); tick();
        clear_inputs(); tick(); tick();
        set_lane(0, F_RS, 12'hB00, 5'd0, 32'h0);
        tick();
        checks++; if (res_rdata !== 32'd1) begin errors++; $display("FAIL mcycle_wrap_lo: got %h want 1", res_rdata); end
        clear_inputs();
        set_lane(0, F_RS, 12'hC80, 5'd0, 32'h0);
        tick();
        checks++; if (res_rdata !== 32'h0000_1235) begin errors++; $display("FAIL mcycle_wrap_hi: got %h want 1235", res_rdata); end
        clear_inputs(); set_wb(12'hB02, 32'd10); retire_cnt = 2'd2; tick();
        clear_inputs(); retire_cnt = 2'd2; repeat (3) tick();
        clear_inputs();
        set_lane(0, F_RS, 12'hC02, 5'd0, 32'h0);
        tick();
        checks++; if (res_rdata !== 32'd16) begin errors++; $display("FAIL minstret: got %0d want 16", res_rdata); end
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        set_lane(0, F_RW, 12'h340, 5'd1, 32'h1111_1111);
        tick();
        srst_n = 1'b0;
        set_wb(12'h340, 32'h2222_2222);
        tick();
        checks++; if (res_valid !== 1'b0 || res_write !== 1'b0) begin errors++; $display("FAIL reset_mid: valid=%b write=%b want 0/0", res_valid, res_write); end
        srst_n = 1'b1;
        clear_inputs();
        set_lane(0, F_RS, 12'h340, 5'd0, 32'h0);
        tick();
        checks++; if (res_rdata !== 32'd0) begin errors++; $display("FAIL reset_mid_state: got %h want 0", res_rdata); end
    endtask

    task automatic test_random();
        logic [11:0] pool [18] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342,
                                   12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                                   12'hC02, 12'hC82, 12'hF14, 12'h7C0, 12'h344, 12'hF11};
        int f3s [6] = '{1, 2, 3, 5, 6, 7};
        for (int n = 0; n < 400; n++) begin
            clear_inputs();
            srst_n = ($urandom_range(0, 49) != 0);
            for (int ln = 0; ln < NL; ln++) begin
                if ($urandom_range(0, 2) != 0) begin
                    set_lane(ln, f3s[$urandom_range(0, 5)], pool[$urandom_range(0, 17)],
                             ($urandom_range(0, 1) != 0) ? 5'($urandom) : 5'd0, $urandom);
                    if ($urandom_range(0, 7) == 0) inst[32*ln+12 +: 3] = ($urandom_range(0, 1) != 0) ? 3'd0 : 3'd4;
                end
            end
            if ($urandom_range(0, 2) == 0) set_wb(pool[$urandom_range(0, 17)], $urandom);
            retire_cnt = 2'($urandom_range(0, NL));
            tick();
            checks++; if (csr_stall !== exp_stall) begin errors++; $display("FAIL rnd_stall[%0d]: got %b want %b", n, csr_stall, exp_stall); end
            checks++; if (res_valid !== exp_valid || res_illegal !== exp_illegal || res_write !== exp_write) begin errors++; $display("FAIL rnd_flags[%0d]: v/ill/wr=%b%b%b want %b%b%b", n, res_valid, res_illegal, res_write, exp_valid, exp_illegal, exp_write); end
            checks++; if (res_rdata !== exp_rdata) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h want %h", n, res_rdata, exp_rdata); end
            if (exp_valid) begin
                checks++; if (res_lane !== 1'(exp_lane)) begin errors++; $display("FAIL rnd_lane[%0d]: got %0d want %0d", n, res_lane, exp_lane); end
            end
            if (exp_valid && !exp_illegal) begin
                checks++; if (res_wdata !== exp_wdata) begin errors++; $display("FAIL rnd_wdata[%0d]: got %h want %h", n, res_wdata, exp_wdata); end
            end
            if (exp_write) begin
                checks++; if (res_waddr !== exp_waddr) begin errors++; $display("FAIL rnd_waddr[%0d]: got %h want %h", n, res_waddr, exp_waddr); end
            end
        end
    endtask

    initial begin
        srst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_scratch();
        test_stall();
        test_illegal();
        test_bypass();
        test_mstatus();
        test_counters();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
